gbt_link_pattern_tester: RTL

//  Parametrised GBT link test-pattern generator/checker; successor of the free-running

---
 rtl/gbt_link_pattern_tester.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/gbt_link_pattern_tester.sv
// GBT link test-pattern generator (counter / PRBS-31) with a self-synchronising checker,
// lock tracking, saturating error statistics and a heartbeat output.
//   state  | meaning
//   IDLE   | waiting for the first word to seed the prediction
//   SEARCH | counting consecutive good words towards lock
//   LOCKED | link good; bad words are counted as errors
module gbt_link_pattern_tester #(
  parameter int DATA_W     = 64,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4,
  parameter int ERR_W      = 32,
  parameter int TICK_DIV   = 40000000
) (
  input  logic              clk_ik,
  input  logic              rstn_ir,
  input  logic              mode_i,
  input  logic              gen_en_i,
  output logic [DATA_W-1:0] tx_data_o,
  input  logic              rx_valid_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              clear_i,
  output logic [1:0]        state_o,
  output logic              locked_o,
  output logic              err_pulse_o,
  output logic [ERR_W-1:0]  word_err_cnt_o,
  output logic [ERR_W-1:0]  bit_err_cnt_o,
  output logic [7:0]        lock_loss_cnt_o,
  output logic              heartbeat_o
);

  localparam int PC_W = $clog2(DATA_W + 1);
  localparam int GR_W = $clog2(LOCK_CNT + 1);
  localparam int BR_W = $clog2(UNLOCK_CNT + 1);
  localparam int HB_W = $clog2(TICK_DIV);
  localparam logic [GR_W-1:0] LOCK_TC   = GR_W'(LOCK_CNT - 1);
  localparam logic [BR_W-1:0] UNLOCK_TC = BR_W'(UNLOCK_CNT - 1);
  localparam logic [HB_W-1:0] HB_TC     = HB_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SEARCH = 2'b01,
    S_LOCKED = 2'b10
  } state_e;

  // DATA_W serial steps of x^31+x^28+1; the first bit produced ends up in the MSB.
  function automatic logic [DATA_W-1:0] prbs_word(input logic [30:0] seed);
    logic [30:0] s;
    logic        nb;
    prbs_word = '0;
    s = seed;
    for (int i = 0; i < DATA_W; i++) begin
      nb = s[30] ^ s[27];
      s = {s[29:0], nb};
      prbs_word = {prbs_word[DATA_W-2:0], nb};
    end
  endfunction

  function automatic logic [PC_W-1:0] popcnt(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] t;
    popcnt = '0;
    t = v;
    for (int i = 0; i < DATA_W; i++) begin
      popcnt = popcnt + PC_W'(t[0]);
      t = t >> 1;
    end
  endfunction

  logic              mode_q;
  logic              mode_chg;
  logic [DATA_W-1:0] tx_q;
  logic [30:0]       lfsr_q;
  logic [DATA_W-1:0] gen_prbs;
  logic [DATA_W-1:0] prev_q;
  logic [DATA_W-1:0] exp_word;
  logic              rx_good;
  state_e            state_q, state_d;
  logic [GR_W-1:0]   good_q, good_d;
  logic [BR_W-1:0]   bad_q, bad_d;
  logic              cnt_err, lost;
  logic              err_q, loss_q;
  logic [PC_W-1:0]   pc_q;
  logic              err_pulse_q;
  logic [ERR_W-1:0]  word_err_q, bit_err_q;
  logic [ERR_W:0]    bit_sum;
  logic [7:0]        loss_cnt_q;
  logic [HB_W-1:0]   div_q;
  logic              hb_q;

  assign mode_chg = mode_i ^ mode_q;
  assign gen_prbs = prbs_word(lfsr_q);

  // The LFSR is kept apart from tx_q because reset leaves tx at 0 while the LFSR is all-ones.
  always_ff @(posedge clk_ik or negedge rstn_ir) begin
    if (!rstn_ir) begin
      mode_q <= 1'b0;
      tx_q   <= '0;
      lfsr_q <= '1;
    end else begin
      mode_q <= mode_i;
      if (mode_chg) begin
        tx_q   <= '0;
        lfsr_q <= '1;
      end else if (gen_en_i) begin
        if (mode_q) begin
          tx_q   <= gen_prbs;
          lfsr_q <= gen_prbs[30:0];
        end else begin
          tx_q <= tx_q + 1'b1;
        end
      end
    end
  end

  assign exp_word = mode_q ? prbs_word(prev_q[30:0]) : prev_q + 1'b1;
  assign rx_good  = (rx_data_i == exp_word) && !(mode_q && (rx_data_i == '0));

  always_ff @(posedge clk_ik or negedge rstn_ir) begin
    if (!rstn_ir) begin
      state_q <= S_IDLE;
      good_q  <= '0;
      bad_q   <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      if (rx_valid_i) prev_q <= rx_data_i;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    cnt_err = 1'b0;
    lost    = 1'b0;
    if (mode_chg) begin
      state_d = S_IDLE;
      good_d  = '0;
      bad_d   = '0;
    end else if (rx_valid_i) begin
      case (state_q)
        S_IDLE: begin
          state_d = S_SEARCH;
          good_d  = '0;
          bad_d   = '0;
        end
        S_SEARCH: begin
          if (!rx_good) begin
            good_d = '0;
          end else if (good_q == LOCK_TC) begin
            state_d = S_LOCKED;
            good_d  = '0;
            bad_d   = '0;
          end else begin
            good_d = good_q + 1'b1;
          end
        end
        S_LOCKED: begin
          if (rx_good) begin
            bad_d = '0;
          end else begin
            cnt_err = 1'b1;
            if (bad_q == UNLOCK_TC) begin
              state_d = S_SEARCH;
              good_d  = '0;
              bad_d   = '0;
              lost    = 1'b1;
            end else begin
              bad_d = bad_q + 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    state_o  = state_q;
    locked_o = (state_q == S_LOCKED);
  end

  // clear_i also drops the in-flight stage so a coincident error never survives it.
  always_ff @(posedge clk_ik or negedge rstn_ir) begin
    if (!rstn_ir) begin
      err_q  <= 1'b0;
      loss_q <= 1'b0;
      pc_q   <= '0;
    end else if (clear_i) begin
      err_q  <= 1'b0;
      loss_q <= 1'b0;
      pc_q   <= '0;
    end else begin
      err_q  <= cnt_err;
      loss_q <= lost;
      pc_q   <= cnt_err ? popcnt(rx_data_i ^ exp_word) : '0;
    end
  end

  assign bit_sum = {1'b0, bit_err_q} + (ERR_W+1)'(pc_q);

  always_ff @(posedge clk_ik or negedge rstn_ir) begin
    if (!rstn_ir) begin
      err_pulse_q <= 1'b0;
      word_err_q  <= '0;
      bit_err_q   <= '0;
      loss_cnt_q  <= '0;
    end else begin
      err_pulse_q <= err_q;
      if (clear_i) begin
        word_err_q <= '0;
        bit_err_q  <= '0;
        loss_cnt_q <= '0;
      end else begin
        if (err_q && !(&word_err_q)) word_err_q <= word_err_q + 1'b1;
        bit_err_q <= bit_sum[ERR_W] ? '1 : bit_sum[ERR_W-1:0];
        if (loss_q && !(&loss_cnt_q)) loss_cnt_q <= loss_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_ik or negedge rstn_ir) begin
    if (!rstn_ir) begin
      div_q <= '0;
      hb_q  <= 1'b0;
    end else if (div_q == HB_TC) begin
      div_q <= '0;
      hb_q  <= ~hb_q;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign tx_data_o       = tx_q;
  assign err_pulse_o     = err_pulse_q;
  assign word_err_cnt_o  = word_err_q;
  assign bit_err_cnt_o   = bit_err_q;
  assign lock_loss_cnt_o = loss_cnt_q;
  assign heartbeat_o     = hb_q;

endmodule
